// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph table and digit record, common to the
// display decoder and the capture path.
package seven_seg_pkg;

  // All segments off (active-low bus).
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F, entry i at index i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // One recovered display digit; dp = 1 means the decimal point is lit.
  typedef struct packed {
    logic       dp;
    logic [3:0] nib;
  } digit_t;

endpackage

// File: rtl/seven_seg_to_hex.sv
// Reverse glyph lookup: active-low 7-segment pattern -> hex nibble.
// hit is low for any pattern outside the glyph table.
module seven_seg_to_hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nib
);

  // Table entries are unique, so at most one comparison matches.
  always_comb begin
    hit = 1'b0;
    nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i]) begin
        hit = 1'b1;
        nib = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Sniffs a multiplexed active-low seven-segment bus, debounces each digit across
// scans and presents coherent frames on a valid/ready handshake.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,  // 1..8
  parameter int unsigned SETTLE_CYCLES = 4,  // >= 1
  parameter int unsigned STABLE_SCANS  = 3   // 1..15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              seg_i,
  input  logic [NUM_DIGITS-1:0]   an_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   dp_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    bad_pattern_o,
  output logic                    overrun_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 2);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [3:0]            STABLE_N   = 4'(STABLE_SCANS);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  // Settle tracking
  logic [7:0]            prev_seg_q;
  logic [NUM_DIGITS-1:0] prev_an_q;
  logic [CNT_W-1:0]      settle_q, settle_d;
  logic                  in_change;

  // Digit select decode
  logic [NUM_DIGITS-1:0] an_act;
  logic                  one_hot;
  logic [IDX_W-1:0]      idx;
  logic                  strobe;

  // Glyph lookup
  logic       hit;
  logic [3:0] hex_nib;
  digit_t     sample;

  // Per-digit debounce state
  digit_t                cand_q   [NUM_DIGITS];
  digit_t                cand_d   [NUM_DIGITS];
  logic [3:0]            match_q  [NUM_DIGITS];
  logic [3:0]            match_d  [NUM_DIGITS];
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                shadow_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] committed_q, committed_d;
  logic                  bad_d;

  // Frame assembly
  logic [4*NUM_DIGITS-1:0] shadow_nibs;
  logic [NUM_DIGITS-1:0]   shadow_dps;
  logic                    first_pending_q;
  logic                    shadow_changed;
  logic                    emit;
  logic                    valid_d;

  seven_seg_to_hex u_to_hex (
    .seg (seg_i[6:0]),
    .hit (hit),
    .nib (hex_nib)
  );

  assign sample.dp  = ~seg_i[7];
  assign sample.nib = hex_nib;
  assign an_act     = ~an_i;

  // Settle counter next state, one-hot check and sample strobe.
  always_comb begin
    in_change = (seg_i != prev_seg_q) || (an_i != prev_an_q);
    if (in_change) begin
      settle_d = '0;
    end else if (settle_q == SETTLE_MAX) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + CNT_W'(1);
    end
    one_hot = (an_act != '0) && ((an_act & (an_act - AN_ONE)) == '0);
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_act[k]) idx = IDX_W'(k);
    end
    // Fires only on the cycle the counter arrives at saturation.
    strobe = one_hot && (settle_d == SETTLE_MAX) && (settle_q != SETTLE_MAX);
  end

  // Debounce, commit and frame-emit decision.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cand_d[k]   = cand_q[k];
      match_d[k]  = match_q[k];
      shadow_d[k] = shadow_q[k];
    end
    committed_d = committed_q;
    bad_d       = bad_pattern_o;
    if (strobe) begin
      if (!hit) begin
        bad_d          = 1'b1;
        match_d[idx]   = 4'd0;
      end else begin
        if (sample == cand_q[idx]) begin
          if (match_q[idx] != 4'hF) match_d[idx] = match_q[idx] + 4'd1;
        end else begin
          cand_d[idx]  = sample;
          match_d[idx] = 4'd1;
        end
        if (match_d[idx] == STABLE_N && match_q[idx] != STABLE_N) begin
          shadow_d[idx]    = sample;
          committed_d[idx] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      shadow_nibs[4*k +: 4] = shadow_d[k].nib;
      shadow_dps[k]         = shadow_d[k].dp;
    end
    // Compare against the last emitted frame, which is what digits_o/dp_o hold.
    shadow_changed = first_pending_q || (shadow_nibs != digits_o) || (shadow_dps != dp_o);
    emit = (&committed_d) && shadow_changed;
    if (emit) begin
      valid_d = 1'b1;
    end else if (frame_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = frame_valid_o;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_seg_q      <= SEG_BLANK;
      prev_an_q       <= '1;
      settle_q        <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        cand_q[k]   <= '0;
        match_q[k]  <= '0;
        shadow_q[k] <= '0;
      end
      committed_q     <= '0;
      first_pending_q <= 1'b1;
      digits_o        <= '0;
      dp_o            <= '0;
      frame_valid_o   <= 1'b0;
      bad_pattern_o   <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      prev_seg_q  <= seg_i;
      prev_an_q   <= an_i;
      settle_q    <= settle_d;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        cand_q[k]   <= cand_d[k];
        match_q[k]  <= match_d[k];
        shadow_q[k] <= shadow_d[k];
      end
      committed_q   <= committed_d;
      bad_pattern_o <= bad_d;
      frame_valid_o <= valid_d;
      if (emit) begin
        digits_o        <= shadow_nibs;
        dp_o            <= shadow_dps;
        first_pending_q <= 1'b0;
        if (frame_valid_o && !frame_ready_i) overrun_o <= 1'b1;
      end
    end
  end

endmodule
